freq_counter_scheduler: RTL and testbench

FREQ_COUNTER_SCHEDULER -- requirements
Module: freq_counter_scheduler

---
 rtl/freq_counter_pkg.sv | 21 ++
 rtl/freq_counter_tick_gen.sv | 28 ++
 rtl/freq_counter_scheduler.sv | 163 ++++++++++++++++
 tb/tb_freq_counter_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: shared FSM state type, AXI response codes and result register map
//   for freq_counter_scheduler and its prescaler.
package freq_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_NEXT = 2'd3
    } state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [11:0] RESULT_BASE_ADDR = 12'h010;
    localparam int          RESULT_STRIDE    = 4;

    // Byte address of the result register of channel ch.
    function automatic logic [11:0] ch_addr(input logic [11:0] base, input logic [3:0] ch);
        return base + 12'(RESULT_STRIDE) * {8'd0, ch};
    endfunction

endpackage

// File: rtl/freq_counter_tick_gen.sv
// freq_counter_tick_gen: sweep prescaler, counts 0..P-1 while enabled and strobes tick at P-1.
//   aclk   in  clock
//   rst_n  in  asynchronous active-low reset (already synchronised on release)
//   enable in  counting enable; counter held at 0 while low
//   tick   out one-cycle strobe when the count sits at P-1
module freq_counter_tick_gen #(
    parameter int P = 2
) (
    input  logic aclk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(P);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && cnt_q == CW'(P - 1);
        cnt_d = (!enable || tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/freq_counter_scheduler.sv
// freq_counter_scheduler: periodically sweeps NUM_CH frequency_counter result registers over
//   an AXI4-Lite read master and reports each value as a one-cycle strobe.
//   aclk, aresetn                      clock, asynchronous active-low reset
//   enable                             polling enable
//   m_arvalid/m_arready/m_araddr       AXI4-Lite read-address channel (master)
//   m_rvalid/m_rready/m_rdata/m_rresp  AXI4-Lite read-data channel (master)
//   result_valid/result_ch/result_data one-cycle result strobe per good read
//   sweep_done                         pulse after the last channel of a sweep
//   rresp_err/overrun/timeout_err      sticky flags, cleared on enable falling edge
// Optional: define FREQ_COUNTER_SCHEDULER_TIMEOUT_EN to add the 8-bit ADDR/DATA watchdog
//   that drives timeout_err; otherwise timeout_err is tied to 0.
module freq_counter_scheduler
    import freq_counter_pkg::*;
#(
    parameter int          ACLK_FREQUENCY = 200000000,
    parameter int          POLL_PERIOD_US = 1000,
    parameter int          NUM_CH         = 4,
    parameter logic [11:0] BASE_ADDR      = RESULT_BASE_ADDR
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [11:0] m_araddr,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        result_valid,
    output logic [3:0]  result_ch,
    output logic [31:0] result_data,
    output logic        sweep_done,
    output logic        rresp_err,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int P = ACLK_FREQUENCY / 1000000 * POLL_PERIOD_US;

    // Reset asserts asynchronously but releases only after two clock edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    logic tick;

    freq_counter_tick_gen #(.P(P)) u_tick_gen (
        .aclk   (aclk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    state_e      state_q, state_d;
    logic [3:0]  ch_q, ch_d;
    logic        enable_q;
    logic        result_valid_q, result_valid_d;
    logic [3:0]  result_ch_q, result_ch_d;
    logic [31:0] result_data_q, result_data_d;
    logic        sweep_done_q, sweep_done_d;
    logic        rresp_err_q, rresp_err_d;
    logic        overrun_q, overrun_d;
    logic        last_ch, r_hs, en_fall;

    assign last_ch = ch_q == 4'(NUM_CH - 1);
    assign r_hs    = state_q == ST_DATA && m_rvalid;
    assign en_fall = enable_q && !enable;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tick)      state_d = ST_ADDR;
            ST_ADDR: if (m_arready) state_d = ST_DATA;
            ST_DATA: if (m_rvalid)  state_d = ST_NEXT;
            ST_NEXT: state_d = (last_ch || !enable) ? ST_IDLE : ST_ADDR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ch_d           = state_q == ST_IDLE ? 4'd0 :
                         (state_q == ST_NEXT && state_d == ST_ADDR) ? ch_q + 4'd1 : ch_q;
        result_valid_d = r_hs && m_rresp == AXI_RESP_OKAY;
        result_ch_d    = result_valid_d ? ch_q : result_ch_q;
        result_data_d  = result_valid_d ? m_rdata : result_data_q;
        sweep_done_d   = state_q == ST_NEXT && last_ch;
        // A tick that lands mid-sweep is only recorded, never queued.
        overrun_d      = !en_fall && (overrun_q || (tick && state_q != ST_IDLE));
        rresp_err_d    = !en_fall && (rresp_err_q || (r_hs && m_rresp != AXI_RESP_OKAY));
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            enable_q       <= 1'b0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_data_q  <= '0;
            sweep_done_q   <= 1'b0;
            rresp_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            enable_q       <= enable;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_data_q  <= result_data_d;
            sweep_done_q   <= sweep_done_d;
            rresp_err_q    <= rresp_err_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        m_arvalid    = state_q == ST_ADDR;
        m_araddr     = m_arvalid ? ch_addr(BASE_ADDR, ch_q) : 12'd0;
        m_rready     = state_q == ST_DATA;
        result_valid = result_valid_q;
        result_ch    = result_ch_q;
        result_data  = result_data_q;
        sweep_done   = sweep_done_q;
        rresp_err    = rresp_err_q;
        overrun      = overrun_q;
    end

`ifdef FREQ_COUNTER_SCHEDULER_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'hFF;

    logic [7:0] wd_q, wd_d;
    logic       timeout_err_q, timeout_err_d;

    // Watchdog only observes; the FSM keeps waiting so the AXI handshake stays legal.
    always_comb begin
        wd_d          = (state_d != state_q || !(state_q == ST_ADDR || state_q == ST_DATA)) ? 8'd0 :
                        wd_q == WDOG_LIMIT ? wd_q : wd_q + 8'd1;
        timeout_err_d = !en_fall && (timeout_err_q || wd_q == WDOG_LIMIT);
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_freq_counter_scheduler.sv
// tb_freq_counter_scheduler: self-checking bench for freq_counter_scheduler with an AXI4-Lite
//   slave model, scenario table, randomized sweeps and directed enable/reset sequences.
module tb_freq_counter_scheduler;
    localparam int          NUM_CH = 4;
    localparam int          P      = 20;
    localparam logic [11:0] BASE   = 12'h010;
`ifdef FREQ_COUNTER_SCHEDULER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [11:0] m_araddr;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        result_valid, sweep_done, rresp_err, overrun, timeout_err;
    logic [3:0]  result_ch;
    logic [31:0] result_data;

    freq_counter_scheduler #(
        .ACLK_FREQUENCY (1000000),
        .POLL_PERIOD_US (20),
        .NUM_CH         (NUM_CH),
        .BASE_ADDR      (BASE)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_araddr     (m_araddr),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready),
        .m_rdata      (m_rdata),
        .m_rresp      (m_rresp),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_data  (result_data),
        .sweep_done   (sweep_done),
        .rresp_err    (rresp_err),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [3:0]  resp_mask = '0;
    logic [31:0] data_tbl [NUM_CH];
    logic [11:0] addr_log [$];
    int          ar_cyc [$];
    logic [3:0]  res_ch [$];
    logic [31:0] res_data [$];
    int          done_cnt = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        ar_cyc.delete();
        res_ch.delete();
        res_data.delete();
        done_cnt = 0;
    endtask

    // AXI4-Lite slave with programmable waits plus protocol monitor and result logger.
    initial begin
        logic        arv_prev = 1'b0, rr_prev = 1'b0, pend = 1'b0;
        logic [11:0] ad_prev = '0;
        int          acnt = 0, rcnt = 0, idx = 0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (aresetn) begin
                chk("ar_r_exclusive", {31'd0, m_arvalid & m_rready}, 0);
                if (arv_prev && !m_arready) begin
                    chk("arvalid_held", {31'd0, m_arvalid}, 1);
                    chk("araddr_held", {20'd0, m_araddr}, {20'd0, ad_prev});
                end
                if (arv_prev && m_arready) begin
                    addr_log.push_back(ad_prev);
                    ar_cyc.push_back(cyc);
                    idx  = (int'(ad_prev) - int'(BASE)) / 4;
                    pend = 1'b1;
                    rcnt = 0;
                    acnt = 0;
                end
                if (rr_prev && m_rvalid) pend = 1'b0;
                if (result_valid) begin
                    res_ch.push_back(result_ch);
                    res_data.push_back(result_data);
                end
                if (sweep_done) done_cnt++;
            end else begin
                pend = 1'b0;
                acnt = 0;
                rcnt = 0;
            end
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            if (aresetn && m_arvalid && !pend) begin
                if (acnt >= ar_delay) m_arready = 1'b1;
                else acnt++;
            end
            if (aresetn && pend && m_rready) begin
                if (rcnt >= r_delay) begin
                    m_rvalid = 1'b1;
                    m_rdata  = (idx >= 0 && idx < NUM_CH) ? data_tbl[idx] : 32'hDEAD_BEEF;
                    m_rresp  = (idx >= 0 && idx < NUM_CH && resp_mask[idx]) ? 2'b10 : 2'b00;
                end else rcnt++;
            end
            arv_prev = m_arvalid;
            rr_prev  = m_rready;
            ad_prev  = m_araddr;
        end
    end

    // One full sweep from a fresh enable; expected results come from the read plan.
    task automatic run_scenario(input int a, input int r, input logic [3:0] mask, input bit rnd,
                                input bit e_ovr, input bit e_err, input bit e_to);
        bit got = 1'b0;
        int n = 0;
        enable = 1'b0;
        repeat (2) @(negedge aclk);
        ar_delay  = a;
        r_delay   = r;
        resp_mask = mask;
        for (int k = 0; k < NUM_CH; k++) data_tbl[k] = rnd ? $urandom : 32'(100 * (k + 1));
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge aclk);
            got = sweep_done;
        end
        chk("sweep_done_seen", {31'd0, got}, 1);
        chk("overrun", {31'd0, overrun}, {31'd0, e_ovr});
        chk("rresp_err", {31'd0, rresp_err}, {31'd0, e_err});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, e_to});
        enable = 1'b0;
        @(negedge aclk);
        chk("sweep_done_count", done_cnt, 1);
        chk("read_count", addr_log.size(), NUM_CH);
        for (int k = 0; k < addr_log.size() && k < NUM_CH; k++)
            chk("araddr", {20'd0, addr_log[k]}, 32'(int'(BASE) + 4 * k));
        for (int k = 0; k < NUM_CH; k++) begin
            if (!mask[k]) begin
                if (n < res_ch.size()) begin
                    chk("result_ch", {28'd0, res_ch[n]}, k);
                    chk("result_data", res_data[n], data_tbl[k]);
                end
                n++;
            end
        end
        chk("result_count", res_ch.size(), n);
    endtask

    typedef struct {
        int         a;
        int         r;
        logic [3:0] mask;
        bit         ovr;
        bit         err;
        bit         to;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   rel, a, r;
        bit   seen;
        logic [3:0] mask;
        tbl[0] = '{0, 0,   4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{5, 0,   4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{0, 0,   4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{0, 25,  4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{0, 300, 4'b0000, 1'b1, 1'b0, TO_EN};
        tbl[5] = '{1, 0,   4'b1001, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge aclk);
        chk("rst_arvalid", {31'd0, m_arvalid}, 0);
        chk("rst_araddr", {20'd0, m_araddr}, 0);
        chk("rst_rready", {31'd0, m_rready}, 0);
        chk("rst_result_valid", {31'd0, result_valid}, 0);
        chk("rst_result_data", result_data, 0);
        chk("rst_sweep_done", {31'd0, sweep_done}, 0);
        chk("rst_flags", {29'd0, rresp_err, overrun, timeout_err}, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < 6; i++)
            run_scenario(tbl[i].a, tbl[i].r, tbl[i].mask, 1'b0, tbl[i].ovr, tbl[i].err, tbl[i].to);

        // A sweep occupies NUM_CH*(3+a+r) cycles after the tick; overrun when it reaches P.
        for (int i = 0; i < 8; i++) begin
            a    = $urandom_range(0, 1);
            r    = $urandom_range(0, 1);
            mask = 4'($urandom_range(0, 15));
            run_scenario(a, r, mask, 1'b1, NUM_CH * (3 + a + r) >= P, mask != 0, 1'b0);
        end

        // Back-to-back sweeps start exactly P cycles apart.
        ar_delay  = 0;
        r_delay   = 0;
        resp_mask = '0;
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 200 && ar_cyc.size() < 9; i++) @(negedge aclk);
        chk("period_reads", ar_cyc.size() >= 9, 1);
        if (ar_cyc.size() >= 9) begin
            chk("period_1", ar_cyc[4] - ar_cyc[0], P);
            chk("period_2", ar_cyc[8] - ar_cyc[4], P);
        end
        chk("period_done_count", done_cnt, 2);
        chk("period_overrun", {31'd0, overrun}, 0);
        enable = 1'b0;

        // enable dropped while channel 1 is in DATA.
        repeat (2) @(negedge aclk);
        r_delay   = 3;
        resp_mask = 4'b0001;
        for (int k = 0; k < NUM_CH; k++) data_tbl[k] = $urandom;
        clear_logs();
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge aclk);
            seen = addr_log.size() == 2 && m_rready;
        end
        chk("drop_reached_ch1_data", {31'd0, seen}, 1);
        chk("drop_err_before", {31'd0, rresp_err}, 1);
        enable = 1'b0;
        repeat (60) @(negedge aclk);
        chk("drop_reads", addr_log.size(), 2);
        chk("drop_results", res_ch.size(), 1);
        if (res_ch.size() == 1) begin
            chk("drop_result_ch", {28'd0, res_ch[0]}, 1);
            chk("drop_result_data", res_data[0], data_tbl[1]);
        end
        chk("drop_no_sweep_done", done_cnt, 0);
        chk("drop_flags_cleared", {30'd0, rresp_err, overrun}, 0);
        chk("drop_idle", {30'd0, m_arvalid, m_rready}, 0);

        // Asynchronous reset while channel 1 waits in ADDR.
        r_delay   = 0;
        ar_delay  = 5;
        resp_mask = 4'b0001;
        clear_logs();
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge aclk);
            seen = addr_log.size() == 1 && m_arvalid;
        end
        chk("arst_reached_ch1_addr", {31'd0, seen}, 1);
        chk("arst_addr_before", {20'd0, m_araddr}, 32'(int'(BASE) + 4));
        chk("arst_err_before", {31'd0, rresp_err}, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_arvalid", {31'd0, m_arvalid}, 0);
        chk("arst_araddr", {20'd0, m_araddr}, 0);
        chk("arst_rready", {31'd0, m_rready}, 0);
        chk("arst_result", {27'd0, result_valid, result_ch}, 0);
        chk("arst_result_data", result_data, 0);
        chk("arst_flags", {28'd0, sweep_done, rresp_err, overrun, timeout_err}, 0);
        repeat (3) @(negedge aclk);
        clear_logs();
        aresetn = 1'b1;
        rel = cyc;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge aclk);
            seen = m_arvalid;
        end
        chk("post_reset_sweep", {31'd0, seen}, 1);
        chk("post_reset_latency", cyc - rel >= P, 1);
        chk("post_reset_ch0", {20'd0, m_araddr}, {20'd0, BASE});
        enable = 1'b0;
        repeat (10) @(negedge aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
